// File: rtl/telemetry_uart_tx_pkg.sv
// Shared types and constants for the telemetry UART transmitter.
// Frame geometry lives here so the FSM and the bench agree on it.
package roversPackage;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Cycles per serial bit; integer division truncates toward zero.
  function automatic int calc_baud_div(input int sysclk_freq, input int baud);
    return sysclk_freq / baud;
  endfunction

endpackage

// File: rtl/telemetry_uart_tx_byte_fifo.sv
// Synchronous FIFO with combinational head read; pointers wrap modulo DEPTH.
// Pushes when full and pops when empty are ignored, so count never over/underflows.
module byte_fifo
  import roversPackage::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2) begin : g_depth_min_chk
    $error("byte_fifo: DEPTH must be at least 2");
  end
  if ((1 << PTR_W) != DEPTH) begin : g_depth_pow2_chk
    $error("byte_fifo: DEPTH must be a power of two");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/telemetry_uart_tx.sv
// Buffered 8N1 UART transmitter for telemetry bytes.
//   state | meaning
//   IDLE  | line high, waiting for a buffered byte
//   START | start bit (low) for BAUD_DIV cycles
//   DATA  | 8 data bits LSB first, BAUD_DIV cycles each
//   STOP  | stop bit (high); may chain straight into the next START
module telemetry_uart_tx
  import roversPackage::*;
#(
  parameter int SYSCLK_FREQ = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          sclk,
  input  logic                          rstn,
  input  logic [7:0]                    inData,
  input  logic                          inValid,
  output logic                          inReady,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int BAUD_DIV = calc_baud_div(SYSCLK_FREQ, BAUD);
  localparam int BAUD_W   = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

  if (BAUD_DIV < 2) begin : g_baud_div_chk
    $error("telemetry_uart_tx: SYSCLK_FREQ/BAUD must be at least 2");
  end
  if (UART_STOP_BITS != 1) begin : g_stop_bits_chk
    $error("telemetry_uart_tx: only one stop bit is supported");
  end
  if (UART_DATA_BITS != 8) begin : g_data_bits_chk
    $error("telemetry_uart_tx: only 8 data bits are supported");
  end

  uart_tx_state_t              state;
  logic [BAUD_W-1:0]           baud_cnt;
  logic [2:0]                  bit_idx;
  logic [UART_DATA_BITS-1:0]   shreg;
  logic                        baud_tc;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [7:0]                  fifo_head;

  assign baud_tc  = (baud_cnt == '0);
  assign inReady  = !fifo_full;
  assign busy     = (state != IDLE) || (fifoCount != '0);

  // Pops happen only from IDLE or on the final STOP cycle, so frames chain with no gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) || ((state == STOP) && baud_tc));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_sys (sclk),
    .rst_b   (rstn),
    .push    (inValid),
    .wr_data (inData),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifoCount),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (fifo_pop) begin
            shreg    <= fifo_head;
            baud_cnt <= BAUD_RELOAD;
            txd      <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            txd      <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == LAST_BIT) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[UART_DATA_BITS-1:1]};
              txd     <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_tc) begin
            if (fifo_pop) begin
              shreg    <= fifo_head;
              baud_cnt <= BAUD_RELOAD;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/telemetry_uart_tx.md
TELEMETRY_UART_TX -- requirements
Module: telemetry_uart_tx

Interface
REQ-001 Parameter SYSCLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial line rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 16, transmit byte buffer depth; power of two, at least 2.
REQ-004 sclk  input  1  system clock; all logic on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 inData  input  8  byte offered for transmission.
REQ-007 inValid  input  1  inData is valid this cycle.
REQ-008 inReady  output  1  buffer can accept a byte this cycle.
REQ-009 txd  output  1  UART serial output; idle high.
REQ-010 busy  output  1  frame in progress or buffer non-empty.
REQ-011 fifoCount  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-012 Localparam BAUD_DIV = SYSCLK_FREQ/BAUD, truncated; elaboration SHALL fail if BAUD_DIV < 2.
REQ-013 Frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly BAUD_DIV cycles; frame = 10*BAUD_DIV cycles.
REQ-014 Push occurs on a cycle with inValid=1 and inReady=1; inReady = (fifoCount < FIFO_DEPTH), combinational from the registered count.
REQ-015 When inReady=0, inData is not captured; the producer holds it, and no byte is lost or duplicated.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 In IDLE with the FIFO non-empty, pop the head into the shift register and enter START; txd goes low on the next cycle.
REQ-018 START lasts BAUD_DIV cycles, then DATA.
REQ-019 DATA shifts out 8 bits at BAUD_DIV cycles each, using a 3-bit bit index, then STOP.
REQ-020 On the last STOP cycle: if the FIFO is non-empty, pop and enter START directly, with no idle gap; otherwise enter IDLE.
REQ-021 Latency: a byte pushed at cycle T into an empty FIFO while IDLE is popped at T+1; its start bit begins at T+2.
REQ-022 A push and a pop in the same cycle leave fifoCount unchanged.
REQ-023 There is no bypass: a pop never returns a byte pushed in the same cycle.
REQ-024 FIFO read and write pointers wrap modulo FIFO_DEPTH; fifoCount never exceeds FIFO_DEPTH and never underflows.
REQ-025 txd is driven from a register, so it is glitch-free; it is high in IDLE and STOP.
REQ-026 busy = (state != IDLE) or (fifoCount != 0).

Reset
REQ-027 While rstn=0: txd=1, busy=0, fifoCount=0, inReady=1, state=IDLE, baud counter=0, bit index=0, FIFO pointers=0.
REQ-028 Reset asserted mid-frame aborts the frame immediately (txd high asynchronously) and flushes the FIFO; no partial frame resumes after release.
REQ-029 The first push may occur on the first clock edge after rstn deasserts.

Structure
REQ-030 roversPackage holds uart_tx_state_t (IDLE, START, DATA, STOP) and the constants UART_DATA_BITS=8 and UART_STOP_BITS=1.
REQ-031 Buffering is a sub-module byte_fifo: synchronous, parameterised depth and width, exposing push/pop/count/full/empty.
REQ-032 The baud counter, shift register and FSM live in telemetry_uart_tx.

Verification (SYSCLK_FREQ=1_000_000, BAUD=100_000, so BAUD_DIV=10; FIFO_DEPTH=16)
REQ-033 Single byte: push 0xA5 at T.
- txd low over cycles T+2..T+11.
- Data bits 1,0,1,0,0,1,0,1, 10 cycles each.
- txd high from T+92.
- busy falls at T+102.
REQ-034 Burst: hold inValid=1 with bytes 0x00..0x20 from idle.
- Exactly 17 bytes accepted before inReady first drops.
- Frames back-to-back, start bit immediately after stop bit.
- Received byte order matches push order.
REQ-035 Backpressure: FIFO full, inValid=1, inData=0x3C held.
- Not accepted until a pop frees a slot.
- 0x3C then transmitted exactly once.
REQ-036 Patterns: bytes 0x00 and 0xFF.
- 0x00 gives txd low for 90 cycles, then high 10.
- 0xFF gives txd low 10 cycles, then high 90.
REQ-037 Reset mid-frame: assert rstn=0 during DATA bit 4 with 5 bytes queued.
- txd=1 and fifoCount=0 within the reset cycle.
- After release, no activity until a new push.
REQ-038 Simultaneous push and pop at fifoCount=1: fifoCount stays 1 and the popped byte is the older one.
